// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive buffer behind the UART receiver
// Captures {parity_err, data} on each rising edge of rx_done_i and serves it first-word-fall-through.
module uart_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int CountWidth = $clog2(DEPTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  rx_done_i,
  input  logic                  rx_parity_err_i,
  input  logic [DATA_W-1:0]     rx_data_i,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic [DATA_W-1:0]     rd_data_o,
  output logic                  rd_parity_err_o,
  output logic [CountWidth-1:0] count_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  overrun_o,
  input  logic                  overrun_clr_i
);

  localparam int PtrW = $clog2(DEPTH);

  logic                  r_done_d;
  logic [DATA_W:0]       r_mem [DEPTH];
  logic [PtrW-1:0]       r_wr_ptr;
  logic [PtrW-1:0]       r_rd_ptr;
  logic [CountWidth-1:0] r_count;
  logic                  r_overrun;

  logic w_wr_stb;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_wr_stb = rx_done_i & ~r_done_d;
  assign w_pop    = rd_valid_o & rd_ready_i;
  // A full buffer still accepts a character when the head leaves in the same cycle.
  assign w_push   = w_wr_stb & (~full_o | w_pop);
  assign w_drop   = w_wr_stb & full_o & ~w_pop;

  assign count_o    = r_count;
  assign empty_o    = (r_count == '0);
  assign full_o     = (r_count == CountWidth'(DEPTH));
  assign rd_valid_o = ~empty_o;
  assign overrun_o  = r_overrun;
  assign {rd_parity_err_o, rd_data_o} = r_mem[r_rd_ptr];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_done_d <= 1'b0;
    end else begin
      r_done_d <= rx_done_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (!clear_i && w_push) begin
      r_mem[r_wr_ptr] <= {rx_parity_err_i, rx_data_i};
    end
  end

  // clear_i outranks push, pop and overrun set; array contents are left as they are.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else if (clear_i) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (overrun_clr_i) begin
        r_overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       clear_i;
  logic       rx_done_i;
  logic       rx_parity_err_i;
  logic [7:0] rx_data_i;
  logic       rd_valid_o;
  logic       rd_ready_i;
  logic [7:0] rd_data_o;
  logic       rd_parity_err_o;
  logic [4:0] count_o;
  logic       empty_o;
  logic       full_o;
  logic       overrun_o;
  logic       overrun_clr_i;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  uart_rx_fifo #(.DATA_W(8), .DEPTH(16)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .clear_i         (clear_i),
    .rx_done_i       (rx_done_i),
    .rx_parity_err_i (rx_parity_err_i),
    .rx_data_i       (rx_data_i),
    .rd_valid_o      (rd_valid_o),
    .rd_ready_i      (rd_ready_i),
    .rd_data_o       (rd_data_o),
    .rd_parity_err_o (rd_parity_err_o),
    .count_o         (count_o),
    .empty_o         (empty_o),
    .full_o          (full_o),
    .overrun_o       (overrun_o),
    .overrun_clr_i   (overrun_clr_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic p);
    rx_data_i       = d;
    rx_parity_err_i = p;
    rx_done_i       = 1'b1;
    step();
    rx_done_i       = 1'b0;
    step();
  endtask

  task automatic pop_one();
    rd_ready_i = 1'b1;
    step();
    rd_ready_i = 1'b0;
  endtask

  logic [8:0] q[$];
  logic       prev_done;
  logic       exp_valid;
  logic       do_pop;
  logic       do_stb;
  int         size_before;

  initial begin
    rst_i = 1'b1; clear_i = 1'b0; rx_done_i = 1'b0; rx_parity_err_i = 1'b0;
    rx_data_i = 8'h00; rd_ready_i = 1'b0; overrun_clr_i = 1'b0;
    step(); step();
    check("rst_count", 32'(count_o), 0);
    check("rst_empty", 32'(empty_o), 1);
    check("rst_full", 32'(full_o), 0);
    check("rst_valid", 32'(rd_valid_o), 0);
    check("rst_overrun", 32'(overrun_o), 0);
    check("rst_data", 32'(rd_data_o), 0);
    check("rst_perr", 32'(rd_parity_err_o), 0);
    rst_i = 1'b0;
    step();

    // single character with long done
    rx_data_i = 8'hA5; rx_parity_err_i = 1'b1; rx_done_i = 1'b1;
    step();
    check("long_valid", 32'(rd_valid_o), 1);
    check("long_data", 32'(rd_data_o), 32'hA5);
    check("long_perr", 32'(rd_parity_err_o), 1);
    for (int i = 0; i < 15; i++) step();
    check("long_count", 32'(count_o), 1);
    rx_done_i = 1'b0; rx_parity_err_i = 1'b0;
    step();
    pop_one();
    check("long_empty", 32'(empty_o), 1);

    // fill, overrun, ordered drain
    for (int i = 0; i < 16; i++) push(8'(i), 1'b0);
    check("fill_full", 32'(full_o), 1);
    check("fill_count", 32'(count_o), 16);
    check("fill_ovr_pre", 32'(overrun_o), 0);
    push(8'hFF, 1'b1);
    check("ovr_set", 32'(overrun_o), 1);
    check("ovr_count", 32'(count_o), 16);
    rd_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("drain_valid", 32'(rd_valid_o), 1);
      check("drain_data", 32'(rd_data_o), 32'(i));
      step();
    end
    rd_ready_i = 1'b0;
    check("drain_empty", 32'(empty_o), 1);
    check("drain_ovr_sticky", 32'(overrun_o), 1);
    overrun_clr_i = 1'b1;
    step();
    overrun_clr_i = 1'b0;
    check("ovr_clr", 32'(overrun_o), 0);

    // push and pop together while full
    for (int i = 0; i < 16; i++) push(8'(8'h10 + i), 1'b0);
    rx_data_i = 8'h3C; rx_done_i = 1'b1; rd_ready_i = 1'b1;
    step();
    rx_done_i = 1'b0; rd_ready_i = 1'b0;
    check("pp_full_count", 32'(count_o), 16);
    check("pp_full_ovr", 32'(overrun_o), 0);
    check("pp_full_head", 32'(rd_data_o), 32'h11);
    rd_ready_i = 1'b1;
    for (int i = 1; i < 16; i++) begin
      check("pp_full_order", 32'(rd_data_o), 32'(8'h10 + i));
      step();
    end
    check("pp_full_last", 32'(rd_data_o), 32'h3C);
    step();
    rd_ready_i = 1'b0;
    check("pp_full_empty", 32'(empty_o), 1);

    // push and pop together at count 1
    push(8'h55, 1'b0);
    rx_data_i = 8'h66; rx_done_i = 1'b1; rd_ready_i = 1'b1;
    step();
    rx_done_i = 1'b0; rd_ready_i = 1'b0;
    check("pp_one_count", 32'(count_o), 1);
    check("pp_one_data", 32'(rd_data_o), 32'h66);
    pop_one();

    // random interleave across pointer wraps
    prev_done = 1'b0;
    for (int c = 0; c < 120; c++) begin
      rx_done_i       = (!prev_done) && ($urandom_range(0, 2) != 0);
      rx_data_i       = 8'($urandom);
      rx_parity_err_i = 1'($urandom);
      rd_ready_i      = 1'($urandom);
      #1;
      exp_valid = (q.size() > 0);
      check("wrap_valid", 32'(rd_valid_o), 32'(exp_valid));
      check("wrap_count", 32'(count_o), 32'(q.size()));
      if (exp_valid) check("wrap_entry", 32'({rd_parity_err_o, rd_data_o}), 32'(q[0]));
      do_pop      = exp_valid && rd_ready_i;
      do_stb      = rx_done_i && !prev_done;
      size_before = q.size();
      if (do_pop) void'(q.pop_front());
      if (do_stb && (size_before < 16 || do_pop)) q.push_back({rx_parity_err_i, rx_data_i});
      prev_done = rx_done_i;
      @(posedge clk_i);
      #1;
    end
    rx_done_i = 1'b0;
    rd_ready_i = 1'b1;
    while (q.size() > 0) begin
      check("wrap_tail", 32'({rd_parity_err_o, rd_data_o}), 32'(q[0]));
      void'(q.pop_front());
      step();
    end
    rd_ready_i = 1'b0;
    step();
    check("wrap_empty", 32'(empty_o), 1);

    // clear with 7 entries, overrun set, and a done edge in the same cycle
    for (int i = 0; i < 17; i++) push(8'(8'h40 + i), 1'b0);
    rd_ready_i = 1'b1;
    for (int i = 0; i < 9; i++) step();
    rd_ready_i = 1'b0;
    check("clr_pre_count", 32'(count_o), 7);
    check("clr_pre_ovr", 32'(overrun_o), 1);
    clear_i = 1'b1; rx_data_i = 8'h77; rx_done_i = 1'b1;
    step();
    clear_i = 1'b0;
    check("clr_count", 32'(count_o), 0);
    check("clr_empty", 32'(empty_o), 1);
    check("clr_ovr", 32'(overrun_o), 0);
    step();
    check("clr_no_recapture", 32'(count_o), 0);
    rx_done_i = 1'b0;
    step();
    push(8'h88, 1'b1);
    check("clr_next_count", 32'(count_o), 1);
    check("clr_next_data", 32'(rd_data_o), 32'h88);
    check("clr_next_perr", 32'(rd_parity_err_o), 1);
    pop_one();

    // asynchronous reset mid-run with 5 entries
    for (int i = 0; i < 5; i++) push(8'(8'hC0 + i), 1'b0);
    check("mid_pre_count", 32'(count_o), 5);
    #2;
    rst_i = 1'b1;
    #1;
    check("mid_rst_count", 32'(count_o), 0);
    check("mid_rst_empty", 32'(empty_o), 1);
    check("mid_rst_valid", 32'(rd_valid_o), 0);
    check("mid_rst_ovr", 32'(overrun_o), 0);
    step();
    rst_i = 1'b0;
    step(); step(); step();
    check("post_rst_count", 32'(count_o), 0);
    check("post_rst_valid", 32'(rd_valid_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
